// File: rtl/bp_fe_fetch_buffer.sv
// bp_fe_fetch_buffer
//   Fetch buffer between the FE fetch response stage and the FE-to-BE queue
//   formatter. Each cycle one fetch packet of up to fetch_width_p lanes is
//   accepted. Its masked-in lanes are compacted into a circular buffer of
//   els_p single-instruction entries. The buffer presents one instruction per
//   cycle, first-word-fall-through, and flushes in a single cycle.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   fetch_v_i             fetch packet valid
//   fetch_ready_o         room for a full packet this cycle
//   fetch_pc_i            PC of lane 0; lane i sits at fetch_pc_i + 4*i
//   fetch_instr_i         lane i at [i*instr_width_p +: instr_width_p]
//   fetch_mask_i          per-lane valid, any pattern
//   fetch_metadata_i      branch metadata, copied to every written lane
//   flush_i               discard all contents
//   deq_v_o               head entry valid
//   deq_yumi_i            consumer takes the head entry
//   deq_pc_o, deq_instr_o, deq_metadata_o   head entry fields
//   count_o               number of occupied entries
module bp_fe_fetch_buffer #(
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned instr_width_p    = 32,
    parameter int unsigned fetch_width_p    = 2,
    parameter int unsigned els_p            = 8,
    parameter int unsigned metadata_width_p = 36
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     fetch_v_i,
    output logic                                     fetch_ready_o,
    input  logic [vaddr_width_p-1:0]                 fetch_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0]   fetch_instr_i,
    input  logic [fetch_width_p-1:0]                 fetch_mask_i,
    input  logic [metadata_width_p-1:0]              fetch_metadata_i,
    input  logic                                     flush_i,
    output logic                                     deq_v_o,
    input  logic                                     deq_yumi_i,
    output logic [vaddr_width_p-1:0]                 deq_pc_o,
    output logic [instr_width_p-1:0]                 deq_instr_o,
    output logic [metadata_width_p-1:0]              deq_metadata_o,
    output logic [$clog2(els_p+1)-1:0]               count_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp = $clog2(els_p+1);

    // Elaboration-time parameter legality
    if (fetch_width_p < 1 || fetch_width_p > 4) begin : g_bad_fetch_width
        $error("bp_fe_fetch_buffer: fetch_width_p must be in 1..4");
    end
    if (els_p < 2 || (els_p & (els_p - 1)) != 0 || els_p < 2 * fetch_width_p) begin : g_bad_els
        $error("bp_fe_fetch_buffer: els_p must be a power of 2 and >= 2*fetch_width_p");
    end

    // Pointer and occupancy state
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;

    // Entry storage; contents are meaningless until written, so no reset
    logic [vaddr_width_p-1:0]    pc_mem    [els_p];
    logic [instr_width_p-1:0]    instr_mem [els_p];
    logic [metadata_width_p-1:0] meta_mem  [els_p];

    // Lane compaction: a set lane lands at wptr + (number of set lanes below it)
    logic [cnt_width_lp-1:0] n_c;
    logic [ptr_width_lp-1:0] lane_idx_c [fetch_width_p];
    logic [vaddr_width_p-1:0] lane_pc_c [fetch_width_p];

    logic [cnt_width_lp-1:0] free_c;
    logic enq_fire_c;
    logic deq_fire_c;

    always_comb begin
        n_c = '0;
        for (int i = 0; i < int'(fetch_width_p); i++) begin
            lane_idx_c[i] = wptr_q + ptr_width_lp'(n_c);
            lane_pc_c[i]  = fetch_pc_i + vaddr_width_p'(4 * i);
            if (fetch_mask_i[i]) begin
                n_c = n_c + cnt_width_lp'(1);
            end
        end
    end

    // Handshakes; flush gates both sides so it always wins
    assign free_c        = cnt_width_lp'(els_p) - count_q;
    assign fetch_ready_o = ~flush_i & (free_c >= cnt_width_lp'(fetch_width_p));
    assign deq_v_o       = (count_q != '0) & ~flush_i;
    assign enq_fire_c    = fetch_v_i & fetch_ready_o;
    assign deq_fire_c    = deq_yumi_i & deq_v_o;

    // Next-state for pointers and count
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire_c) begin
                wptr_d = wptr_q + ptr_width_lp'(n_c);
            end
            if (deq_fire_c) begin
                rptr_d = rptr_q + ptr_width_lp'(1);
            end
            count_d = count_q
                    + (enq_fire_c ? n_c : cnt_width_lp'(0))
                    - (deq_fire_c ? cnt_width_lp'(1) : cnt_width_lp'(0));
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage writes; compacted indices are distinct within a packet
    always_ff @(posedge clk_i) begin
        if (enq_fire_c) begin
            for (int i = 0; i < int'(fetch_width_p); i++) begin
                if (fetch_mask_i[i]) begin
                    pc_mem[lane_idx_c[i]]    <= lane_pc_c[i];
                    instr_mem[lane_idx_c[i]] <= fetch_instr_i[i*instr_width_p +: instr_width_p];
                    meta_mem[lane_idx_c[i]]  <= fetch_metadata_i;
                end
            end
        end
    end

    // First-word-fall-through head
    assign deq_pc_o       = pc_mem[rptr_q];
    assign deq_instr_o    = instr_mem[rptr_q];
    assign deq_metadata_o = meta_mem[rptr_q];
    assign count_o        = count_q;

    // Protocol checks; a yumi coinciding with a flush is harmless since flush wins
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(deq_yumi_i && !deq_v_o && !flush_i))
                else $error("bp_fe_fetch_buffer: deq_yumi_i while deq_v_o=0");
            assert (count_q <= cnt_width_lp'(els_p))
                else $error("bp_fe_fetch_buffer: count exceeds els_p");
        end
    end

endmodule
